// File: rtl/periph_bus_pkg.sv
// periph_bus_pkg: shared types and constants for the peripheral bus controller.
//   bus_state_t   controller FSM state (IDLE, BUSY, DONE)
//   src_t         which source drives the core read-data return (MEM, PERIPH)
//   PERIPH_REGION_BIT  address bit splitting data memory from peripherals
//   TIMEOUT_RDATA      read data returned for a timed-out peripheral access
//   LED_BASE, SW_BASE  base addresses of the first two peripheral slots
package periph_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } bus_state_t;

  typedef enum logic {
    MEM    = 1'b0,
    PERIPH = 1'b1
  } src_t;

  localparam int          PERIPH_REGION_BIT = 31;
  localparam logic [31:0] TIMEOUT_RDATA     = 32'hDEAD_BEEF;

  localparam logic [31:0] LED_BASE = 32'h8000_0000;
  localparam logic [31:0] SW_BASE  = 32'h8000_1000;

endpackage

// File: rtl/periph_bus_ctrl_if.sv
// periph_bus_ctrl_if: core LSU data-bus signals.
//   master modport: the core (drives req/we/addr/wdata/be, receives rdata/stall/err)
//   slave modport : the bus controller
// Handshake: the core presents a request with req_i high; while stall_o is high
// in the same cycle the core must hold req_i/we_i/addr_i/wdata_i/be_i stable.
// A request is complete in the first cycle it is seen with stall_o low; read
// data and err_o for a memory access appear the following cycle, for a
// peripheral access in the cycle where stall_o first drops.
interface periph_bus_ctrl_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [3:0]  be_i;
  logic [31:0] rdata_o;
  logic        stall_o;
  logic        err_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i, be_i,
    input  rdata_o, stall_o, err_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, be_i,
    output rdata_o, stall_o, err_o
  );
endinterface

// File: rtl/periph_rdata_mux.sv
// periph_rdata_mux: combinational N_SLOTS:1 mux of 32-bit peripheral read data.
//   p_rdata_i  flattened read data, slot k at bits [32k+31:32k]
//   sel_i      slot index
//   rdata_o    selected word, zero when sel_i is out of range
module periph_rdata_mux #(
  parameter int N_SLOTS = 4,
  parameter int SLOT_W  = 4
) (
  input  logic [32*N_SLOTS-1:0] p_rdata_i,
  input  logic [SLOT_W-1:0]     sel_i,
  output logic [31:0]           rdata_o
);

  always_comb begin
    rdata_o = '0;
    for (int k = 0; k < N_SLOTS; k++) begin
      if (int'(sel_i) == k) rdata_o = p_rdata_i[32*k +: 32];
    end
  end

endmodule

// File: rtl/periph_bus_ctrl.sv
// periph_bus_ctrl: data-bus decoder between the core LSU, data memory and
// N_SLOTS memory-mapped peripheral controllers.
//   clk_i, rst_i       clock, asynchronous active-high reset
//   bus                core-side bus (periph_bus_ctrl_if.slave)
//   mem_req_o/we_o     data memory request, combinational, zero added stall
//   mem_rdata_i        memory read data, valid the cycle after the request
//   p_req_o            one-hot peripheral request, high through BUSY
//   p_we_o/addr_o/wdata_o/be_o  registered copy of the accepted core request
//   p_rdata_i          flattened peripheral read data
//   p_ready_i          per-slot completion, sampled only for the selected slot
//   dbg_state_o        current FSM state
// Optional build macro PERIPH_TIMEOUT_EN: bounds the BUSY wait to
// TIMEOUT_CYCLES cycles and returns an error with TIMEOUT_RDATA on expiry.
module periph_bus_ctrl
  import periph_bus_pkg::*;
#(
  parameter int N_SLOTS        = 4,
  parameter int SLOT_LSB       = 12,
  parameter int SLOT_W         = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  periph_bus_ctrl_if.slave      bus,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  input  logic [31:0]           mem_rdata_i,
  output logic [N_SLOTS-1:0]    p_req_o,
  output logic                  p_we_o,
  output logic [31:0]           p_addr_o,
  output logic [31:0]           p_wdata_o,
  output logic [3:0]            p_be_o,
  input  logic [32*N_SLOTS-1:0] p_rdata_i,
  input  logic [N_SLOTS-1:0]    p_ready_i,
  output bus_state_t            dbg_state_o
);

  bus_state_t         state;
  src_t               src_q;
  logic [SLOT_W-1:0]  slot_q;
  logic [31:0]        rdata_q;
  logic               err_q;

  logic [SLOT_W-1:0]  addr_slot;
  logic               is_periph;
  logic               slot_ok;
  logic               accept_p;
  logic               slot_ready;
  logic [N_SLOTS-1:0] slot_onehot;
  logic [31:0]        mux_rdata;

`ifdef PERIPH_TIMEOUT_EN
  localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_cnt;
`endif

  assign addr_slot = bus.addr_i[SLOT_LSB +: SLOT_W];
  assign is_periph = bus.addr_i[PERIPH_REGION_BIT];
  assign slot_ok   = int'(addr_slot) < N_SLOTS;
  assign accept_p  = (state == IDLE) && bus.req_i && is_periph;

  // p_req_o is one-hot on slot_q throughout BUSY, so masking with it picks
  // out the selected slot's ready and ignores every other slot.
  assign slot_ready = |(p_ready_i & p_req_o);

  always_comb begin
    slot_onehot = '0;
    for (int k = 0; k < N_SLOTS; k++) begin
      if (int'(addr_slot) == k) slot_onehot[k] = 1'b1;
    end
  end

  periph_rdata_mux #(
    .N_SLOTS (N_SLOTS),
    .SLOT_W  (SLOT_W)
  ) u_rdata_mux (
    .p_rdata_i (p_rdata_i),
    .sel_i     (slot_q),
    .rdata_o   (mux_rdata)
  );

  // Memory path is purely combinational and only live in IDLE.
  assign mem_req_o = (state == IDLE) && bus.req_i && !is_periph;
  assign mem_we_o  = mem_req_o && bus.we_i;

  // Stall covers the accept cycle (combinational) and every BUSY cycle; it is
  // forced low during reset so an aborted access releases the core at once.
  assign bus.stall_o = !rst_i && (accept_p || (state == BUSY));
  assign bus.err_o   = (state == DONE) && err_q;
  assign bus.rdata_o = (src_q == PERIPH) ? rdata_q : mem_rdata_i;

  assign dbg_state_o = state;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      src_q     <= MEM;
      slot_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      p_req_o   <= '0;
      p_we_o    <= 1'b0;
      p_addr_o  <= '0;
      p_wdata_o <= '0;
      p_be_o    <= '0;
`ifdef PERIPH_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_i && !is_periph) begin
            src_q <= MEM;
          end else if (bus.req_i) begin
            src_q <= PERIPH;
            if (slot_ok) begin
              slot_q    <= addr_slot;
              p_req_o   <= slot_onehot;
              p_we_o    <= bus.we_i;
              p_addr_o  <= bus.addr_i;
              p_wdata_o <= bus.wdata_i;
              p_be_o    <= bus.be_i;
`ifdef PERIPH_TIMEOUT_EN
              tmo_cnt   <= '0;
`endif
              state     <= BUSY;
            end else begin
              // Unmapped slot: no peripheral is touched, fault straight away.
              err_q   <= 1'b1;
              rdata_q <= '0;
              state   <= DONE;
            end
          end
        end

        BUSY: begin
          // Ready is checked first so it wins over a simultaneous expiry.
          if (slot_ready) begin
            rdata_q <= p_we_o ? 32'h0 : mux_rdata;
            err_q   <= 1'b0;
            p_req_o <= '0;
            state   <= DONE;
          end
`ifdef PERIPH_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            rdata_q <= TIMEOUT_RDATA;
            err_q   <= 1'b1;
            p_req_o <= '0;
            tmo_cnt <= tmo_cnt + 1'b1;
            state   <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end

        DONE: begin
          // The request still visible here is the one being retired.
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_periph_bus_ctrl.sv
// tb_periph_bus_ctrl: directed bench for periph_bus_ctrl with N_SLOTS=4.
// Covers reset values, memory read/write, peripheral write and delayed read,
// unmapped slot, busy-wait (timeout when PERIPH_TIMEOUT_EN is defined) and
// reset in the middle of a peripheral access.
module tb_periph_bus_ctrl;
  import periph_bus_pkg::*;

  localparam int N_SLOTS = 4;

  logic                  clk_i;
  logic                  rst_i;
  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [31:0]           mem_rdata_i;
  logic [N_SLOTS-1:0]    p_req_o;
  logic                  p_we_o;
  logic [31:0]           p_addr_o;
  logic [31:0]           p_wdata_o;
  logic [3:0]            p_be_o;
  logic [32*N_SLOTS-1:0] p_rdata_i;
  logic [N_SLOTS-1:0]    p_ready_i;
  bus_state_t            dbg_state;

  int vectors;
  int miscompares;
  int stall_cnt;
  int busy_cnt;

  periph_bus_ctrl_if bus ();

  periph_bus_ctrl #(
    .N_SLOTS        (N_SLOTS),
    .SLOT_LSB       (12),
    .SLOT_W         (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .bus         (bus),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_rdata_i (mem_rdata_i),
    .p_req_o     (p_req_o),
    .p_we_o      (p_we_o),
    .p_addr_o    (p_addr_o),
    .p_wdata_o   (p_wdata_o),
    .p_be_o      (p_be_o),
    .p_rdata_i   (p_rdata_i),
    .p_ready_i   (p_ready_i),
    .dbg_state_o (dbg_state)
  );

  // clock
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish within 100000 time units");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_i);
  endtask

  task automatic drive_req(input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
    bus.req_i   = req;
    bus.we_i    = we;
    bus.addr_i  = addr;
    bus.wdata_i = wdata;
    bus.be_i    = 4'hF;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_i       = 1'b1;
    drive_req(1'b0, 1'b0, 32'h0, 32'h0);
    mem_rdata_i = 32'h5A5A_5A5A;
    p_ready_i   = '0;
    p_rdata_i   = {32'h3333_3333, 32'h2222_2222, 32'h0000_00F0, 32'h1111_1111};

    // ---- reset values
    sample();
    check("rst_state", dbg_state, IDLE);
    check("rst_p_req", p_req_o, 4'b0000);
    check("rst_p_regs", {p_we_o, p_be_o}, 5'h00);
    check("rst_p_addr", p_addr_o, 32'h0);
    check("rst_p_wdata", p_wdata_o, 32'h0);
    check("rst_stall_err", {bus.stall_o, bus.err_o}, 2'b00);
    check("rst_rdata_follows_mem", bus.rdata_o, 32'h5A5A_5A5A);
    tick();
    rst_i = 1'b0;
    tick();

    // ---- 1. memory read
    drive_req(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    sample();
    check("t1_mem_req", {mem_req_o, mem_we_o}, 2'b10);
    check("t1_stall", bus.stall_o, 1'b0);
    tick();
    drive_req(1'b0, 1'b0, 32'h0, 32'h0);
    mem_rdata_i = 32'h1234_5678;
    sample();
    check("t1_rdata", bus.rdata_o, 32'h1234_5678);
    check("t1_err", bus.err_o, 1'b0);

    // memory write: combinational write enable
    drive_req(1'b1, 1'b1, 32'h0000_0100, 32'h0000_0077);
    sample();
    check("t1w_mem_req_we", {mem_req_o, mem_we_o, bus.stall_o}, 3'b110);
    tick();
    drive_req(1'b0, 1'b0, 32'h0, 32'h0);

    // ---- 2. LED write, ready tied high
    p_ready_i = 4'b0001;
    drive_req(1'b1, 1'b1, LED_BASE, 32'h0000_00A5);
    sample();
    check("t2_accept_stall", bus.stall_o, 1'b1);
    check("t2_accept_p_req", p_req_o, 4'b0000);
    check("t2_accept_mem_req", mem_req_o, 1'b0);
    tick();
    sample();
    check("t2_busy_state", dbg_state, BUSY);
    check("t2_busy_stall", bus.stall_o, 1'b1);
    check("t2_busy_p_req", p_req_o, 4'b0001);
    check("t2_busy_p_wdata", p_wdata_o, 32'h0000_00A5);
    check("t2_busy_p_we_addr", {p_we_o, p_addr_o}, {1'b1, LED_BASE});
    tick();
    sample();
    check("t2_done_state", dbg_state, DONE);
    check("t2_done_stall_err", {bus.stall_o, bus.err_o}, 2'b00);
    check("t2_done_p_req", p_req_o, 4'b0000);
    check("t2_done_rdata_write_zero", bus.rdata_o, 32'h0);
    tick();
    drive_req(1'b0, 1'b0, 32'h0, 32'h0);
    sample();
    check("t2_back_idle", dbg_state, IDLE);
    tick();

    // ---- 3. switch read, ready in the third BUSY cycle; other slots' ready high
    p_ready_i = 4'b1101;
    stall_cnt = 0;
    drive_req(1'b1, 1'b0, SW_BASE, 32'h0);
    sample();
    if (bus.stall_o) stall_cnt++;
    tick();
    // core inputs change while BUSY; registered copies must hold
    drive_req(1'b1, 1'b0, 32'h0000_0044, 32'hFFFF_FFFF);
    sample();
    if (bus.stall_o) stall_cnt++;
    check("t3_busy_p_req", p_req_o, 4'b0010);
    check("t3_busy_p_addr_held", p_addr_o, SW_BASE);
    check("t3_busy_no_mem_req", mem_req_o, 1'b0);
    tick();
    drive_req(1'b1, 1'b0, SW_BASE, 32'h0);
    sample();
    if (bus.stall_o) stall_cnt++;
    check("t3_busy_ignores_other_ready", dbg_state, BUSY);
    tick();
    p_ready_i = 4'b0010;
    sample();
    if (bus.stall_o) stall_cnt++;
    tick();
    p_ready_i = 4'b1111;
    sample();
    check("t3_stall_cycles", stall_cnt, 4);
    check("t3_done_stall", bus.stall_o, 1'b0);
    check("t3_done_rdata", bus.rdata_o, 32'h0000_00F0);
    check("t3_done_err", bus.err_o, 1'b0);
    tick();
    drive_req(1'b0, 1'b0, 32'h0, 32'h0);
    p_ready_i = 4'b0000;
    sample();
    check("t3_no_reaccept", {dbg_state, p_req_o}, {IDLE, 4'b0000});
    tick();

    // ---- 4. unmapped slot 7
    drive_req(1'b1, 1'b0, 32'h8000_7000, 32'h0);
    sample();
    check("t4_accept_stall", bus.stall_o, 1'b1);
    check("t4_accept_p_req", p_req_o, 4'b0000);
    tick();
    sample();
    check("t4_done_state", dbg_state, DONE);
    check("t4_done_err", bus.err_o, 1'b1);
    check("t4_done_rdata", bus.rdata_o, 32'h0);
    check("t4_done_stall_p_req", {bus.stall_o, p_req_o}, 5'b0);
    tick();
    drive_req(1'b0, 1'b0, 32'h0, 32'h0);
    sample();
    check("t4_err_one_cycle", bus.err_o, 1'b0);
    tick();

    // ---- 5. slot 2 with no ready
`ifdef PERIPH_TIMEOUT_EN
    drive_req(1'b1, 1'b0, 32'h8000_2000, 32'h0);
    tick();
    busy_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      sample();
      if (dbg_state == BUSY && bus.stall_o && !bus.err_o) busy_cnt++;
      tick();
    end
    sample();
    check("t5_tmo_busy_cycles", busy_cnt, 16);
    check("t5_tmo_state", dbg_state, DONE);
    check("t5_tmo_err", bus.err_o, 1'b1);
    check("t5_tmo_rdata", bus.rdata_o, TIMEOUT_RDATA);
    check("t5_tmo_p_req", p_req_o, 4'b0000);
    tick();
    drive_req(1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // ready arrives in the 16th BUSY cycle: normal completion wins
    drive_req(1'b1, 1'b0, 32'h8000_2000, 32'h0);
    tick();
    for (int i = 0; i < 16; i++) begin
      if (i == 15) p_ready_i = 4'b0100;
      tick();
    end
    p_ready_i = 4'b0000;
    sample();
    check("t5_late_ready_err", bus.err_o, 1'b0);
    check("t5_late_ready_rdata", bus.rdata_o, 32'h2222_2222);
    tick();
    drive_req(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
`else
    drive_req(1'b1, 1'b0, 32'h8000_2000, 32'h0);
    tick();
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      sample();
      if (dbg_state == BUSY && bus.stall_o && !bus.err_o) busy_cnt++;
      tick();
    end
    check("t5_wait_busy_cycles", busy_cnt, 40);
    p_ready_i = 4'b0100;
    tick();
    p_ready_i = 4'b0000;
    sample();
    check("t5_wait_done_err", bus.err_o, 1'b0);
    check("t5_wait_done_rdata", bus.rdata_o, 32'h2222_2222);
    tick();
    drive_req(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
`endif

    // ---- 6. reset during slot-0 BUSY
    drive_req(1'b1, 1'b0, LED_BASE, 32'h0);
    tick();
    sample();
    check("t6_busy_p_req", p_req_o, 4'b0001);
    #2;
    rst_i       = 1'b1;
    mem_rdata_i = 32'hCAFE_F00D;
    #1;
    check("t6_rst_p_req", p_req_o, 4'b0000);
    check("t6_rst_stall", bus.stall_o, 1'b0);
    check("t6_rst_err", bus.err_o, 1'b0);
    check("t6_rst_state", dbg_state, IDLE);
    check("t6_rst_rdata_mem", bus.rdata_o, 32'hCAFE_F00D);
    tick();
    drive_req(1'b0, 1'b0, 32'h0, 32'h0);
    rst_i = 1'b0;
    sample();
    check("t6_after_rst_err", {bus.err_o, bus.stall_o}, 2'b00);
    tick();
    drive_req(1'b1, 1'b0, 32'h0000_0020, 32'h0);
    sample();
    check("t6_mem_req", {mem_req_o, bus.stall_o}, 2'b10);
    tick();
    drive_req(1'b0, 1'b0, 32'h0, 32'h0);
    mem_rdata_i = 32'h0BAD_F00D;
    sample();
    check("t6_mem_rdata", bus.rdata_o, 32'h0BAD_F00D);
    check("t6_mem_err", bus.err_o, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/periph_bus_ctrl.md
Name: periph_bus_ctrl

Overview:
- Parametrised data-bus decoder/controller between the core LSU and the data memory plus N_SLOTS memory-mapped peripheral controllers (LED, switches, UART, timer, ...).
- Routes `addr_i[31]=0` to data memory with zero added stall.
- Routes `addr_i[31]=1` to the peripheral slot selected by `addr_i[SLOT_LSB+SLOT_W-1:SLOT_LSB]`.
- Peripheral accesses use a req/ready handshake with core stall, a registered read-data return and an error response for unmapped or unresponsive slots.

Parameters:
- N_SLOTS, 4, number of peripheral slots; 1..2**SLOT_W.
- SLOT_LSB, 12, LSB of the slot index field in the address.
- SLOT_W, 4, width of the slot index field.
- TIMEOUT_CYCLES, 16, BUSY cycles allowed before error; only used with the optional feature; must be ≥1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- req_i  in  1  core data request.
- we_i  in  1  core write enable.
- addr_i  in  32  core address.
- wdata_i  in  32  core write data.
- be_i  in  4  core byte enables.
- rdata_o  out  32  read data to core.
- stall_o  out  1  core must hold its request.
- err_o  out  1  one-cycle access-fault pulse.
- mem_req_o  out  1  data memory request.
- mem_we_o  out  1  data memory write enable.
- mem_rdata_i  in  32  memory read data, valid the cycle after the request.
- p_req_o  out  N_SLOTS  one-hot peripheral request.
- p_we_o  out  1  peripheral write enable (registered).
- p_addr_o  out  32  peripheral address (registered).
- p_wdata_o  out  32  peripheral write data (registered).
- p_be_o  out  4  peripheral byte enables (registered).
- p_rdata_i  in  32*N_SLOTS  peripheral read data, flattened; slot k occupies bits [32k+31:32k].
- p_ready_i  in  N_SLOTS  per-slot completion, valid while that slot's p_req_o is high.

Behaviour:
- Clock, reset and reset values:
  - Clocked on posedge clk_i; async active-high reset.
  - Reset values: state=IDLE, p_req_o=0, p_we_o=0, p_addr_o=0, p_wdata_o=0, p_be_o=0, stall_o=0, err_o=0, src_q=MEM, rdata_q=0, timeout counter=0.
  - During reset rdata_o follows mem_rdata_i.
- Memory path (addr_i[31]=0, state IDLE):
  - mem_req_o=req_i and mem_we_o=req_i&we_i, both combinational.
  - stall_o=0.
  - src_q<=MEM on any accepted request; rdata_o=mem_rdata_i in the following cycle.
  - mem_req_o=0 whenever addr_i[31]=1 or state≠IDLE.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, req_i&addr_i[31], slot<N_SLOTS:
    - Latch we/addr/wdata/be into the p_* registers and the slot into slot_q.
    - Go to BUSY; stall_o=1 combinationally in this same cycle.
  - IDLE, req_i&addr_i[31], slot≥N_SLOTS:
    - Set err_q=1 and rdata_q=0; go to DONE.
    - stall_o=1 in this cycle; no p_req_o is asserted.
  - BUSY:
    - p_req_o[slot_q]=1, all other bits 0; stall_o=1.
    - On p_ready_i[slot_q]=1: rdata_q<=slot_q's word of p_rdata_i (0 for writes), err_q<=0, go to DONE.
    - p_ready_i bits of unselected slots are ignored.
  - DONE:
    - stall_o=0, rdata_o=rdata_q, err_o=err_q, p_req_o=0.
    - Next state is IDLE unconditionally. The request visible in DONE is the one being retired and is never re-accepted.
    - src_q=PERIPH.
- Latency:
  - Peripheral access with ready in the first BUSY cycle: 3 cycles total (accept, BUSY, DONE) with 2 stall cycles.
  - Memory access: 0 stall.
- Ignored core inputs: while in BUSY, changes on core inputs are ignored because the registered copies drive the peripheral side.
- Back-to-back: a new request is accepted in the IDLE cycle after DONE.
- Reset mid-operation: the FSM returns to IDLE immediately and p_req_o drops asynchronously. The pending access is dropped with no response and no err_o pulse.
- err_o is high only in DONE; it is never asserted for memory accesses.

Optional Feature:
- Macro: PERIPH_TIMEOUT_EN.
- Defined:
  - A $clog2(TIMEOUT_CYCLES+1)-bit counter clears on BUSY entry and increments each BUSY cycle without ready.
  - When it reaches TIMEOUT_CYCLES with no ready, go to DONE with err_q=1 and rdata_q=32'hDEAD_BEEF.
  - Ready arriving in the same cycle as expiry wins (normal completion).
- Not defined: BUSY waits indefinitely for p_ready_i and the counter logic is absent.

Decomposition:
- Package periph_bus_pkg holds:
  - Typedef bus_state_t {IDLE, BUSY, DONE}.
  - Typedef src_t {MEM, PERIPH}.
  - Constants PERIPH_REGION_BIT=31 and TIMEOUT_RDATA=32'hDEAD_BEEF.
  - Per-slot base-address constants: LED=32'h8000_0000, SW=32'h8000_1000.
- One natural sub-module: periph_rdata_mux, a combinational N_SLOTS:1 32-bit mux indexed by slot_q.

Test Plan:
1. Memory read: addr_i=32'h0000_0010, req_i=1, we_i=0, mem_rdata_i=32'h1234_5678 the next cycle -> mem_req_o=1, stall_o=0; next cycle rdata_o=32'h1234_5678, err_o=0.
2. LED write: addr_i=32'h8000_0000, we_i=1, wdata_i=32'hA5, p_ready_i[0] tied to 1 -> stall_o=1 for 2 cycles, p_req_o=4'b0001 and p_wdata_o=32'hA5 for 1 cycle, mem_req_o=0; DONE has stall_o=0, err_o=0.
3. Switch read with delayed ready: addr_i=32'h8000_1000, p_ready_i[1] asserted 3 cycles after BUSY entry with word=32'h0000_00F0 -> stall_o=1 for 4 cycles, then rdata_o=32'h0000_00F0 for one cycle.
4. Unmapped slot: addr_i=32'h8000_7000 with N_SLOTS=4 -> p_req_o stays 0, one stall cycle, then err_o=1 and rdata_o=0 in DONE.
5. Timeout (PERIPH_TIMEOUT_EN, TIMEOUT_CYCLES=16): slot 2 never ready -> err_o=1 and rdata_o=32'hDEAD_BEEF after 16 BUSY cycles. Ready on cycle 16 instead -> normal data, err_o=0.
6. Reset mid-BUSY: assert rst_i during slot-0 BUSY -> p_req_o=0 and stall_o=0 immediately, no err_o; after release a memory read completes normally.
